uc_boot_mem: RTL and testbench
==============================

# uc_boot_mem

Program/data memory for the 8-bit microcontroller, with a built-in byte-stream boot loader. After reset it holds the core in reset, fills its 256x8 array from a valid/ready loader stream (length, payload, checksum), then releases the core. It serves the core's shared bidirectional memory bus (address, write enable, data) for fetch, LOAD and STORE.

## Interface
- ADDR_WIDTH, 8, address width; array depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 8, word and stream byte width.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_ready  out  1  block accepts a loader byte this cycle.
- boot_skip  in  1  when high in S_LEN, go straight to S_RUN with no load.
- mem_addr  in  8  core bus address.
- mem_write_en  in  1  core STORE strobe; high means the core drives mem_data.
- mem_data  inout  8  bidirectional data bus.
- uc_rst  out  1  reset to the core, active-low; low means the core is held.
- boot_done  out  1  load finished or skipped; core running.
- boot_err  out  1  last frame failed its checksum.

## Operation
- States: S_LEN, S_DATA, S_CSUM, S_RUN.
- A transfer occurs on a rising edge with ld_valid && ld_ready.
- ld_ready = 1 in S_LEN, S_DATA and S_CSUM; 0 in S_RUN; forced 0 while rst is low.
- S_LEN:
  - boot_skip=1 has priority and moves to S_RUN.
  - Otherwise an accepted byte sets remaining = byte (0 means 256), clears wr_ptr and sum, clears boot_err, and moves to S_DATA.
- S_DATA, on each accepted byte:
  - mem[wr_ptr] <= byte; wr_ptr++ (8-bit wrap); sum <= sum + byte (mod 256); remaining--.
  - When the byte that makes remaining 0 is accepted, move to S_CSUM.
- S_CSUM, on the accepted byte:
  - byte == sum: move to S_RUN.
  - Otherwise set boot_err=1 and return to S_LEN. Bytes already written stay in the array.
- S_RUN is terminal until reset:
  - boot_done=1, ld_ready=0, loader inputs ignored.
- Bus, in every state:
  - mem_write_en=0: block drives mem_data = mem[mem_addr] (asynchronous read).
  - mem_write_en=1: block tri-states mem_data, and the rising edge writes mem[mem_addr] <= mem_data.
  - Core writes are honoured only in S_RUN. In other states the core is in reset and mem_write_en is ignored for writing, but the tri-state rule still applies.
- The memory array is not reset. Contents survive rst.

## Timing
- Reset values, asserted asynchronously on rst low: state=S_LEN, uc_rst=0, boot_done=0, boot_err=0, ld_ready=0, wr_ptr=0, sum=0, remaining=0.
- First accept is possible on the first rising edge after rst rises.
- Each byte is accepted in one cycle; back-to-back transfers run at 1 byte/cycle. Gaps in ld_valid just stall.
- Entering S_RUN:
  - boot_done goes high on the same edge as the transition.
  - uc_rst is registered and goes high on the following edge, so the core leaves reset 1 cycle after boot_done.
- A payload byte is readable on the bus the cycle after its accepting edge.
- A core STORE is visible to a read of the same address the cycle after the write edge. A same-cycle read returns the old value.
- boot_err is set on the mismatching checksum edge and cleared on the next accepted length byte.
- Reset asserted mid-load aborts the frame immediately. Already-written bytes remain, and the next frame restarts at S_LEN.

## Test plan
- Good short frame: stream 0x03, 0x11, 0x22, 0x33, 0x66.
  - boot_done=1 on the checksum edge; uc_rst=1 one cycle later.
  - Reads at addr 0/1/2 return 0x11/0x22/0x33.
- Bad checksum then retry: stream 0x02, 0xAA, 0x01, 0x00.
  - boot_err=1, state back to S_LEN, uc_rst stays 0.
  - Resend with checksum 0xAB: boot_err clears on the length byte and boot_done=1.
- Full 256-byte frame: length 0x00, payload bytes 0x00..0xFF, checksum 0x80.
  - boot_done=1; addr 0xFF reads 0xFF; wr_ptr wrapped with no overrun.
- Stall handling: ld_valid toggled randomly across a 4-byte frame.
  - Only handshaked bytes are written, in order; correct checksum gives boot_done.
- Run-time bus in S_RUN: mem_write_en=1, addr 0x40, bus driven 0xA5.
  - Block does not drive mem_data during the write.
  - Next cycle, with mem_write_en=0, addr 0x40 reads 0xA5.
- Reset and skip:
  - rst pulsed low after 2 payload bytes: all outputs take reset values immediately; earlier bytes are still readable.
  - boot_skip=1 at restart gives boot_done=1 on the first edge and uc_rst=1 on the next.

Source files
------------

// File: rtl/uc_boot_mem.sv
// 256x8 program/data memory with a length/payload/checksum byte-stream boot loader.
// Holds the core in reset until a frame loads cleanly (or boot is skipped).
module uc_boot_mem #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  input  logic                  boot_skip,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_write_en,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  uc_rst,
  output logic                  boot_done,
  output logic                  boot_err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  // One extra bit so a length byte of 0 can stand for 2^DATA_WIDTH bytes.
  localparam int unsigned CntW  = DATA_WIDTH + 1;

  typedef enum logic [1:0] {StLen, StData, StCsum, StRun} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic [CntW-1:0]       remaining_q;
  logic                  boot_done_q;
  logic                  boot_err_q;
  logic                  uc_rst_q;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic                  accept;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign ld_ready  = rst && (state_q != StRun);
  assign accept    = ld_valid && ld_ready;
  assign boot_done = boot_done_q;
  assign boot_err  = boot_err_q;
  assign uc_rst    = uc_rst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StLen;
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      remaining_q <= '0;
      boot_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
      uc_rst_q    <= 1'b0;
    end else begin
      // Core leaves reset one cycle after boot_done rises.
      uc_rst_q <= boot_done_q;
      unique case (state_q)
        StLen: begin
          if (boot_skip) begin
            state_q     <= StRun;
            boot_done_q <= 1'b1;
          end else if (accept) begin
            remaining_q <= (ld_data == '0) ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, ld_data};
            wr_ptr_q    <= '0;
            sum_q       <= '0;
            boot_err_q  <= 1'b0;
            state_q     <= StData;
          end
        end
        StData: begin
          if (accept) begin
            wr_ptr_q    <= wr_ptr_q + ADDR_WIDTH'(1);
            sum_q       <= sum_q + ld_data;
            remaining_q <= remaining_q - CntW'(1);
            if (remaining_q == CntW'(1)) state_q <= StCsum;
          end
        end
        StCsum: begin
          if (accept) begin
            if (ld_data == sum_q) begin
              state_q     <= StRun;
              boot_done_q <= 1'b1;
            end else begin
              boot_err_q <= 1'b1;
              state_q    <= StLen;
            end
          end
        end
        StRun: ;
        default: state_q <= StLen;
      endcase
    end
  end

  // Loader owns the write port while loading; the core only once running.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = ld_data;
    if (state_q == StData && accept) begin
      mem_we = 1'b1;
    end else if (state_q == StRun && mem_write_en) begin
      mem_we    = 1'b1;
      mem_waddr = mem_addr;
      mem_wdata = mem_data;
    end
  end

  // Array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign mem_data = mem_write_en ? {DATA_WIDTH{1'bz}} : mem[mem_addr];

endmodule

// File: tb/tb_uc_boot_mem.sv
// Directed self-checking bench for uc_boot_mem: good/bad frames, full frame, stalls,
// run-time bus writes, reset mid-load and boot skip.
module tb_uc_boot_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       boot_skip;
  logic [7:0] mem_addr;
  logic       mem_write_en;
  wire  [7:0] mem_data;
  logic [7:0] bus_drv;
  logic       uc_rst;
  logic       boot_done;
  logic       boot_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mem_data = mem_write_en ? bus_drv : 8'bz;

  uc_boot_mem #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .boot_skip   (boot_skip),
    .mem_addr    (mem_addr),
    .mem_write_en(mem_write_en),
    .mem_data    (mem_data),
    .uc_rst      (uc_rst),
    .boot_done   (boot_done),
    .boot_err    (boot_err)
  );

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; boot_skip = 1'b0;
    mem_addr = 8'h00; mem_write_en = 1'b0; bus_drv = 8'h00;
    #12;
    n_checks++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %b want 0", ld_ready); else n_pass++;
    n_checks++; if (uc_rst !== 1'b0) $display("FAIL reset_uc_rst: got %b want 0", uc_rst); else n_pass++;
    n_checks++; if (boot_done !== 1'b0) $display("FAIL reset_boot_done: got %b want 0", boot_done); else n_pass++;
    n_checks++; if (boot_err !== 1'b0) $display("FAIL reset_boot_err: got %b want 0", boot_err); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (ld_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", ld_ready); else n_pass++;
  endtask

  task automatic test_good_frame();
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    n_checks++; if (boot_done !== 1'b0) $display("FAIL good_pre_csum_done: got %b want 0", boot_done); else n_pass++;
    send_byte(8'h66);
    n_checks++; if (boot_done !== 1'b1) $display("FAIL good_boot_done: got %b want 1", boot_done); else n_pass++;
    n_checks++; if (uc_rst !== 1'b0) $display("FAIL good_uc_rst_same_edge: got %b want 0", uc_rst); else n_pass++;
    n_checks++; if (ld_ready !== 1'b0) $display("FAIL good_ld_ready_run: got %b want 0", ld_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (uc_rst !== 1'b1) $display("FAIL good_uc_rst_next: got %b want 1", uc_rst); else n_pass++;
    mem_addr = 8'h00; #1;
    n_checks++; if (mem_data !== 8'h11) $display("FAIL good_rd0: got %h want 11", mem_data); else n_pass++;
    mem_addr = 8'h01; #1;
    n_checks++; if (mem_data !== 8'h22) $display("FAIL good_rd1: got %h want 22", mem_data); else n_pass++;
    mem_addr = 8'h02; #1;
    n_checks++; if (mem_data !== 8'h33) $display("FAIL good_rd2: got %h want 33", mem_data); else n_pass++;
  endtask

  task automatic test_bad_retry();
    do_reset();
    send_byte(8'h02); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00);
    n_checks++; if (boot_err !== 1'b1) $display("FAIL bad_boot_err: got %b want 1", boot_err); else n_pass++;
    n_checks++; if (boot_done !== 1'b0) $display("FAIL bad_boot_done: got %b want 0", boot_done); else n_pass++;
    n_checks++; if (ld_ready !== 1'b1) $display("FAIL bad_ld_ready: got %b want 1", ld_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (uc_rst !== 1'b0) $display("FAIL bad_uc_rst: got %b want 0", uc_rst); else n_pass++;
    send_byte(8'h02);
    n_checks++; if (boot_err !== 1'b0) $display("FAIL retry_err_clear: got %b want 0", boot_err); else n_pass++;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hAB);
    n_checks++; if (boot_done !== 1'b1) $display("FAIL retry_boot_done: got %b want 1", boot_done); else n_pass++;
    mem_addr = 8'h01; #1;
    n_checks++; if (mem_data !== 8'h01) $display("FAIL retry_rd1: got %h want 01", mem_data); else n_pass++;
  endtask

  task automatic test_full_frame();
    do_reset();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    n_checks++; if (boot_done !== 1'b0) $display("FAIL full_pre_csum_done: got %b want 0", boot_done); else n_pass++;
    send_byte(8'h80);
    n_checks++; if (boot_done !== 1'b1) $display("FAIL full_boot_done: got %b want 1", boot_done); else n_pass++;
    n_checks++; if (boot_err !== 1'b0) $display("FAIL full_boot_err: got %b want 0", boot_err); else n_pass++;
    mem_addr = 8'hFF; #1;
    n_checks++; if (mem_data !== 8'hFF) $display("FAIL full_rdFF: got %h want ff", mem_data); else n_pass++;
    mem_addr = 8'h00; #1;
    n_checks++; if (mem_data !== 8'h00) $display("FAIL full_rd00: got %h want 00", mem_data); else n_pass++;
    mem_addr = 8'h80; #1;
    n_checks++; if (mem_data !== 8'h80) $display("FAIL full_rd80: got %h want 80", mem_data); else n_pass++;
  endtask

  task automatic test_stall();
    logic [7:0] pay [4];
    pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30; pay[3] = 8'h40;
    do_reset();
    send_byte(8'h04);
    for (int i = 0; i < 4; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        ld_data = 8'hEE;
        @(negedge clk);
      end
      send_byte(pay[i]);
    end
    ld_data = 8'hEE;
    @(negedge clk);
    send_byte(8'hA0);
    n_checks++; if (boot_done !== 1'b1) $display("FAIL stall_boot_done: got %b want 1", boot_done); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      mem_addr = 8'(i); #1;
      n_checks++;
      if (mem_data !== pay[i]) $display("FAIL stall_rd%0d: got %h want %h", i, mem_data, pay[i]);
      else n_pass++;
    end
    mem_addr = 8'h04; #1;
    n_checks++; if (mem_data !== 8'h04) $display("FAIL stall_rd4_untouched: got %h want 04", mem_data); else n_pass++;
  endtask

  task automatic test_run_bus();
    @(negedge clk);
    mem_addr = 8'h40; bus_drv = 8'hA5; mem_write_en = 1'b1; #1;
    n_checks++; if (mem_data !== 8'hA5) $display("FAIL bus_no_drive: got %h want a5", mem_data); else n_pass++;
    @(negedge clk);
    mem_write_en = 1'b0; #1;
    n_checks++; if (mem_data !== 8'hA5) $display("FAIL bus_store_read: got %h want a5", mem_data); else n_pass++;
  endtask

  task automatic test_reset_skip();
    do_reset();
    send_byte(8'h03); send_byte(8'h5A); send_byte(8'hC3);
    // Core write while loading must be ignored.
    mem_addr = 8'h02; bus_drv = 8'h77; mem_write_en = 1'b1;
    @(negedge clk);
    mem_write_en = 1'b0; #1;
    n_checks++; if (mem_data !== 8'h30) $display("FAIL load_core_wr_ignored: got %h want 30", mem_data); else n_pass++;
    rst = 1'b0; #1;
    n_checks++; if (ld_ready !== 1'b0) $display("FAIL midrst_ld_ready: got %b want 0", ld_ready); else n_pass++;
    n_checks++; if (boot_done !== 1'b0) $display("FAIL midrst_boot_done: got %b want 0", boot_done); else n_pass++;
    n_checks++; if (uc_rst !== 1'b0) $display("FAIL midrst_uc_rst: got %b want 0", uc_rst); else n_pass++;
    mem_addr = 8'h00; #1;
    n_checks++; if (mem_data !== 8'h5A) $display("FAIL midrst_rd0: got %h want 5a", mem_data); else n_pass++;
    mem_addr = 8'h01; #1;
    n_checks++; if (mem_data !== 8'hC3) $display("FAIL midrst_rd1: got %h want c3", mem_data); else n_pass++;
    boot_skip = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (boot_done !== 1'b1) $display("FAIL skip_boot_done: got %b want 1", boot_done); else n_pass++;
    n_checks++; if (uc_rst !== 1'b0) $display("FAIL skip_uc_rst_first: got %b want 0", uc_rst); else n_pass++;
    @(negedge clk);
    n_checks++; if (uc_rst !== 1'b1) $display("FAIL skip_uc_rst_next: got %b want 1", uc_rst); else n_pass++;
    boot_skip = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_retry();
    test_full_frame();
    test_stall();
    test_run_bus();
    test_reset_skip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
